// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: slow-clock tick extractor, phase countdown and tick watchdog; TRAFFIC_PAUSE_EN adds a pause input
module traffic_phase_timer #(
  parameter int DUR_W = 6,
  parameter int TICK_TIMEOUT = 120_000_000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             load,
  input  logic [DUR_W-1:0] duration,
  input  logic             clear_lost,
`ifdef TRAFFIC_PAUSE_EN
  input  logic             pause,
`endif
  output logic             tick,
  output logic             busy,
  output logic [DUR_W-1:0] remaining,
  output logic             done,
  output logic             tick_lost
);
  localparam int WD_W = $clog2(TICK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TICK_TIMEOUT - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic s1, s2, s3;
  logic hold;
  logic done_nx;
  logic [DUR_W-1:0] rem_nx;
  logic [WD_W-1:0] wd_cnt;
`ifdef TRAFFIC_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  assign busy = (state == RUN);
  // synchronise slow_clk and strobe its rising edge; chain resets high so a level already high is not an edge
  always_ff @(posedge clk_in) begin
    if (reset) begin
      {s1, s2, s3} <= 3'b111;
      tick <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= s2;
      tick <= s2 & ~s3;
    end
  end
  // phase state, remaining count and done pulse registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
      remaining <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      remaining <= rem_nx;
      done <= done_nx;
    end
  end
  // load only from IDLE; a zero-length phase completes immediately without entering RUN
  always_comb begin
    state_nx = state;
    rem_nx = remaining;
    done_nx = 1'b0;
    case (state)
      IDLE:
        if (load) begin
          if (duration != '0) begin
            state_nx = RUN;
            rem_nx = duration;
          end else begin
            done_nx = 1'b1;
          end
        end
      RUN:
        if (tick && !hold) begin
          rem_nx = remaining - DUR_W'(1);
          done_nx = (remaining == DUR_W'(1));
          state_nx = done_nx ? IDLE : RUN;
        end
      default: state_nx = IDLE;
    endcase
  end
  // count tick-less cycles; saturate and latch tick_lost at the limit, clear_lost overrides everything
  always_ff @(posedge clk_in) begin
    if (reset || clear_lost) begin
      wd_cnt <= '0;
      tick_lost <= 1'b0;
    end else begin
      tick_lost <= tick_lost | (wd_cnt == WD_MAX);
      wd_cnt <= tick ? '0 : (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + WD_W'(1);
    end
  end
endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer: randomized and directed bench against a behavioural phase/watchdog model
module tb_traffic_phase_timer;
  localparam int T = 20;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic slow_clk = 1'b1;
  logic load = 1'b0;
  logic [5:0] duration = '0;
  logic clear_lost = 1'b0;
`ifdef TRAFFIC_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic tick, busy, done, tick_lost;
  logic [5:0] remaining;
  int checks = 0;
  int failures = 0;
  int hp = 0;
  int pc = 0;
  bit sq[$];
  bit m_tick, m_act, m_done, m_lost;
  int m_rem, gap;

  traffic_phase_timer #(.DUR_W(6), .TICK_TIMEOUT(T)) dut (
    .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk), .load(load),
    .duration(duration), .clear_lost(clear_lost),
`ifdef TRAFFIC_PAUSE_EN
    .pause(pause),
`endif
    .tick(tick), .busy(busy), .remaining(remaining), .done(done), .tick_lost(tick_lost)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: optional slow-clock toggling, model update at the edge, then output comparison
  task automatic cyc();
    bit t, pz;
    if (hp > 0) begin
      pc++;
      if (pc >= hp) begin
        slow_clk = ~slow_clk;
        pc = 0;
      end
    end
    @(posedge clk_in);
    t = m_tick;
`ifdef TRAFFIC_PAUSE_EN
    pz = pause;
`else
    pz = 1'b0;
`endif
    if (reset) begin
      sq = '{1'b1, 1'b1, 1'b1};
      m_tick = 0; m_act = 0; m_rem = 0; m_done = 0; gap = 0; m_lost = 0;
    end else begin
      sq.push_front(slow_clk);
      m_tick = sq[2] && !sq[3];
      void'(sq.pop_back());
      m_done = 0;
      if (!m_act) begin
        if (load) begin
          if (duration != 0) begin
            m_act = 1;
            m_rem = int'(duration);
          end else m_done = 1;
        end
      end else if (t && !pz) begin
        if (m_rem == 1) begin
          m_act = 0;
          m_done = 1;
        end
        m_rem--;
      end
      if (clear_lost) begin
        gap = 0;
        m_lost = 0;
      end else begin
        if (gap >= T - 1) m_lost = 1;
        gap = t ? 0 : gap + 1;
      end
    end
    #1;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("busy", 32'(busy), 32'(m_act));
    chk("remaining", 32'(remaining), 32'(m_rem));
    chk("done", 32'(done), 32'(m_done));
    chk("tick_lost", 32'(tick_lost), 32'(m_lost));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_tick();
    for (int i = 0; i < 100 && tick !== 1'b1; i++) cyc();
    chk("wait_tick", 32'(tick), 32'd1);
  endtask

  task automatic wait_rem(input int v);
    for (int i = 0; i < 200 && int'(remaining) != v; i++) cyc();
    chk("wait_rem", 32'(remaining), 32'(v));
  endtask

  initial begin
    run(2);
    reset = 1'b0;
    run(6);
    slow_clk = 1'b0;
    run(4);
    slow_clk = 1'b1;
    run(6);
    hp = 4;
    load = 1'b1; duration = 6'd3;
    cyc();
    load = 1'b0;
    chk("load3_rem", 32'(remaining), 32'd3);
    run(40);
    hp = 0;
    load = 1'b1; duration = 6'd0;
    cyc();
    load = 1'b0;
    chk("zero_done", 32'(done), 32'd1);
    run(3);
    hp = 3;
    wait_tick();
    load = 1'b1; duration = 6'd5;
    cyc();
    load = 1'b0;
    chk("coll_rem", 32'(remaining), 32'd5);
    wait_rem(4);
    load = 1'b1; duration = 6'd9;
    cyc();
    load = 1'b0;
    chk("reload_rem", 32'(remaining), 32'd4);
    run(60);
    hp = 0; slow_clk = 1'b0;
    run(30);
    chk("lost_set", 32'(tick_lost), 32'd1);
    hp = 3;
    run(20);
    chk("lost_sticky", 32'(tick_lost), 32'd1);
    clear_lost = 1'b1;
    cyc();
    clear_lost = 1'b0;
    chk("lost_clr", 32'(tick_lost), 32'd0);
    load = 1'b1; duration = 6'd4;
    cyc();
    load = 1'b0;
    wait_rem(2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_rem", 32'(remaining), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    run(10);
`ifdef TRAFFIC_PAUSE_EN
    load = 1'b1; duration = 6'd6;
    cyc();
    load = 1'b0;
    wait_rem(5);
    pause = 1'b1;
    run(14);
    chk("pause_rem", 32'(remaining), 32'd5);
    pause = 1'b0;
    run(60);
`endif
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) hp = $urandom_range(0, 8);
      load = ($urandom_range(0, 15) == 0);
      duration = 6'($urandom_range(0, 7));
      clear_lost = ($urandom_range(0, 149) == 0);
      reset = ($urandom_range(0, 399) == 0);
`ifdef TRAFFIC_PAUSE_EN
      pause = ($urandom_range(0, 3) == 0);
`endif
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Receiving end of the slow 1 Hz toggle clock produced by the design's clock divider.
- Samples the slow clock as data in the clk_in domain (no second clock domain) and converts each rising edge into a one-cycle tick strobe.
- Runs a loadable seconds countdown for traffic-light phase durations, pulsing done at expiry.
- Includes a watchdog that flags a dead or missing slow clock.

Parameters:
- DUR_W, 6, width of duration/remaining in ticks (max phase 63 ticks).
- TICK_TIMEOUT, 120_000_000, clk_in cycles without a tick before tick_lost is set; watchdog counter width $clog2(TICK_TIMEOUT+1).

Ports:
- clk_in  input  1  system clock (50 MHz).
- reset  input  1  synchronous, active-high reset.
- slow_clk  input  1  divided slow clock, treated as asynchronous data.
- load  input  1  start request, honoured only when busy=0.
- duration  input  DUR_W  phase length in ticks, sampled on the load cycle.
- clear_lost  input  1  clears tick_lost and the watchdog counter.
- tick  output  1  one-cycle strobe per slow_clk rising edge.
- busy  output  1  countdown in progress.
- remaining  output  DUR_W  ticks left in the current phase.
- done  output  1  one-cycle pulse at phase expiry.
- tick_lost  output  1  sticky watchdog flag.

Behaviour:
- Reset: one clock, synchronous, active-high; all actions below occur on the clk_in rising edge with reset=1.
  - Sync chain s1/s2/s3 is set to 1 (a slow_clk already high at reset produces no tick).
  - tick=0, busy=0, remaining=0, done=0, tick_lost=0, watchdog count=0, FSM=IDLE.
  - Reset mid-countdown aborts the phase with no done pulse.
- Edge detect: s1<=slow_clk, s2<=s1, s3<=s2, tick<=s2&~s3.
  - tick goes high after the 3rd clk_in edge at which slow_clk is sampled high.
  - tick is high for exactly 1 cycle per rising edge of slow_clk.
  - Falling edges are ignored.
- FSM states:
  - IDLE (busy=0)
  - RUN (busy=1)
- IDLE with load=1 and duration>0:
  - Next cycle: RUN, remaining=duration.
  - A tick in the same cycle as load is not counted; the first counted tick is strictly after the load cycle.
- IDLE with load=1 and duration=0:
  - Stay IDLE; done=1 for 1 cycle on the next cycle; remaining stays 0.
- RUN with tick=1:
  - If remaining>1: remaining decrements by 1.
  - If remaining==1: next cycle remaining=0, done=1, busy=0, state=IDLE.
- RUN with load=1: ignored, with no effect on remaining.
- Expiry latency: after load, done asserts in the cycle following the duration-th counted tick.
- done and tick are never held high for more than 1 cycle.
- Watchdog:
  - Count increments every cycle tick=0 and clears to 0 on tick=1.
  - When the count reaches TICK_TIMEOUT-1, tick_lost is set (sticky) and the count saturates.
  - Runs in both FSM states.
  - tick_lost does not stop the countdown.
  - clear_lost=1 clears tick_lost and the count next cycle.
  - clear_lost coincident with the saturation event: clear wins.
  - tick coincident with saturation: the count clears, and tick_lost is still set.
- remaining is a pure register output, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: TRAFFIC_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in RUN, ticks are not counted, busy stays 1, remaining holds, and the watchdog still runs.
  - A tick coincident with pause=1 is discarded, not deferred.
  - pause has no effect in IDLE.
- Undefined: the pause port is absent, and every tick in RUN is counted.

Test Plan:
- Reset and slow_clk edges:
  - Assert reset with slow_clk=1, then release -> no tick.
  - Drive slow_clk 0 then 1 -> tick=1 for exactly 1 cycle, 3 edges after the first high sample; busy=0, remaining=0.
- Normal countdown:
  - Apply load with duration=3, then 3 slow_clk rising edges -> remaining steps 3,2,1,0.
  - done pulses once, the cycle after the 3rd counted tick; busy falls in the same cycle.
- Zero duration and collisions:
  - load with duration=0 -> done 1 cycle later, busy never 1.
  - load with duration=5 coincident with a tick -> remaining=5 (tick not counted).
- Reload while running:
  - During RUN with remaining=4, pulse load with duration=9 -> remaining stays 4.
  - Phase completes normally.
- Watchdog (TICK_TIMEOUT=20):
  - Hold slow_clk low -> tick_lost=1 after 20 cycles without a tick; remains set when ticks resume.
  - Pulse clear_lost -> tick_lost=0.
- Mid-operation reset and pause:
  - Reset at remaining=2 -> remaining=0, busy=0, no done.
  - With TRAFFIC_PAUSE_EN defined, pause=1 across 2 ticks -> remaining unchanged.
